// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and hazard controller state encoding.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hazard_state_t;

  // Number of DRAIN cycles is DRAIN_LAST + 1 when no memory stall intervenes.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags a decode-stage instruction that reads the
// register a load in EX is about to write. Pure combinational.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_usesRt,
  output logic     loadUse
);

  // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
  always_comb begin
    loadUse = idex_dREN && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (ifid_usesRt && (idex_rt == ifid_rt)));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory stalls, EX redirects, load-use bubbles,
// fetch misses and the halt drain sequence.
// Optional: define HAZARD_STATS_EN to add the saturating stall_count output.
module hazard_control_unit
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     idex_dREN,
  input  logic     idex_halt,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_usesRt,
  input  logic     exmem_dREN,
  input  logic     exmem_dWEN,
  input  logic     dhit,
  input  logic     ihit,
  input  logic     ex_redirect,
  output logic     pc_en,
  output logic     ifid_en,
  output logic     idex_en,
  output logic     exmem_en,
  output logic     memwb_en,
  output logic     ifid_flush,
  output logic     idex_flush,
  output logic     halt
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  hazard_state_t state, nextState;
  logic [1:0]    drainCnt, nextDrainCnt;
  logic          loadUse;
  logic          memStall;

  load_use_detect u_load_use_detect (
    .idex_dREN   (idex_dREN),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .ifid_usesRt (ifid_usesRt),
    .loadUse     (loadUse)
  );

  // An outstanding data access that has not hit freezes the whole pipe.
  always_comb begin
    memStall = (exmem_dREN | exmem_dWEN) & ~dhit;
  end

  // Stage control decode and next-state logic; priority is
  // mem stall > redirect > load-use > fetch miss, with halt overlaid in RUN.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    nextState    = state;
    nextDrainCnt = drainCnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;

    case (state)
      RUN: begin
        if (memStall) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          nextState = MEM_WAIT;
        end else begin
          if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (loadUse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
          // Halt in EX stops fetch and starts draining the older instructions.
          if (idex_halt) begin
            pc_en        = 1'b0;
            ifid_flush   = 1'b1;
            nextState    = DRAIN;
            nextDrainCnt = 2'd0;
          end
        end
      end

      MEM_WAIT: begin
        if (dhit) begin
          nextState = RUN;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end
      end

      DRAIN: begin
        if (memStall) begin
          // Freeze everything, including the drain counter.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (drainCnt == DRAIN_LAST) begin
            nextState = HALTED;
          end else begin
            nextDrainCnt = drainCnt + 2'd1;
          end
        end
      end

      HALTED: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      end

      default: begin
        nextState = RUN;
      end
    endcase
  end

  // State, drain counter and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      drainCnt <= 2'd0;
      halt     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample pre-edge values regardless of statement order.
      state    <= nextState;
      drainCnt <= nextDrainCnt;
      halt     <= (nextState == HALTED);
    end
  end

`ifdef HAZARD_STATS_EN
  // Count every cycle fetch is held, except once halted; saturates at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count <= 16'd0;
    end else if (!pc_en && (state != HALTED) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
module tb_hazard_control_unit;
  import cpu_types_pkg::*;

  logic     CLK;
  logic     nRST;
  logic     idex_dREN, idex_halt, ifid_usesRt;
  regbits_t idex_rt, ifid_rs, ifid_rt;
  logic     exmem_dREN, exmem_dWEN, dhit, ihit, ex_redirect;
  logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic     ifid_flush, idex_flush, halt;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
  logic [6:0] ctrl;
  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  localparam logic [6:0] C_RUN   = 7'b1111100;
  localparam logic [6:0] C_ALL0  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b0011101;
  localparam logic [6:0] C_REDIR = 7'b1111111;
  localparam logic [6:0] C_IMISS = 7'b0111110;
  localparam logic [6:0] C_HALTR = 7'b0111110;
  localparam logic [6:0] C_DRAIN = 7'b0111111;

  int testsRun    = 0;
  int testsFailed = 0;

  hazard_control_unit dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .idex_dREN   (idex_dREN),
    .idex_halt   (idex_halt),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .ifid_usesRt (ifid_usesRt),
    .exmem_dREN  (exmem_dREN),
    .exmem_dWEN  (exmem_dWEN),
    .dhit        (dhit),
    .ihit        (ihit),
    .ex_redirect (ex_redirect),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .halt        (halt)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkStats(input string tag, input logic [15:0] exp);
`ifdef HAZARD_STATS_EN
    check(tag, stall_count, exp);
`else
    if (exp === 16'hxxxx) $display("unused %s", tag);
`endif
  endtask

  // Quiet inputs: fetch hits, no memory traffic, no hazards.
  task automatic idle();
    idex_dREN   = 1'b0;
    idex_halt   = 1'b0;
    idex_rt     = '0;
    ifid_rs     = '0;
    ifid_rt     = '0;
    ifid_usesRt = 1'b0;
    exmem_dREN  = 1'b0;
    exmem_dWEN  = 1'b0;
    dhit        = 1'b0;
    ihit        = 1'b1;
    ex_redirect = 1'b0;
  endtask

  // Move to 1ns after the next rising edge; inputs are then driven and
  // outputs sampled 1ns later, far from either clock edge.
  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    #3;
    nRST = 1'b1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #2;
    check("reset_ctrl", {9'd0, ctrl}, {9'd0, C_RUN});
    check("reset_halt", {15'd0, halt}, 16'd0);
    checkStats("reset_stats", 16'd0);
    #10;
    nRST = 1'b1;

    // Idle RUN
    nextCycle(); idle(); #1;
    check("run_idle", {9'd0, ctrl}, {9'd0, C_RUN});

    // Load-use through rs: one bubble cycle, then normal flow
    nextCycle(); idle(); idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; #1;
    check("lu_rs", {9'd0, ctrl}, {9'd0, C_LU});
    nextCycle(); idle(); #1;
    check("lu_rs_after", {9'd0, ctrl}, {9'd0, C_RUN});

    // Load-use through rt only when the instruction reads rt
    nextCycle(); idle(); idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3;
    ifid_rt = 5'd7; ifid_usesRt = 1'b1; #1;
    check("lu_rt", {9'd0, ctrl}, {9'd0, C_LU});
    nextCycle(); idle(); idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3;
    ifid_rt = 5'd7; ifid_usesRt = 1'b0; #1;
    check("lu_rt_unused", {9'd0, ctrl}, {9'd0, C_RUN});

    // Load to register zero never stalls
    nextCycle(); idle(); idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; #1;
    check("lu_r0", {9'd0, ctrl}, {9'd0, C_RUN});

    // Fetch miss
    nextCycle(); idle(); ihit = 1'b0; #1;
    check("imiss", {9'd0, ctrl}, {9'd0, C_IMISS});

    // Redirect beats a simultaneous load-use and fetch miss
    nextCycle(); idle(); ex_redirect = 1'b1; ihit = 1'b0;
    idex_dREN = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9; #1;
    check("redir_lu", {9'd0, ctrl}, {9'd0, C_REDIR});

    // Memory stall outranks redirect
    nextCycle(); idle(); exmem_dWEN = 1'b1; ex_redirect = 1'b1; #1;
    check("memst_redir", {9'd0, ctrl}, {9'd0, C_ALL0});
    nextCycle(); idle(); dhit = 1'b1; #1;
    check("memst_redir_hit", {9'd0, ctrl}, {9'd0, C_RUN});

    // Three-cycle data miss from a clean reset
    nextCycle(); idle(); doReset();
    for (int i = 0; i < 3; i++) begin
      nextCycle(); idle(); exmem_dREN = 1'b1; dhit = 1'b0; #1;
      check($sformatf("memwait_%0d", i), {9'd0, ctrl}, {9'd0, C_ALL0});
    end
    nextCycle(); idle(); exmem_dREN = 1'b1; dhit = 1'b1; #1;
    check("memwait_hit", {9'd0, ctrl}, {9'd0, C_RUN});
    checkStats("memwait_stats", 16'd3);
    nextCycle(); idle(); #1;
    check("memwait_done", {9'd0, ctrl}, {9'd0, C_RUN});
    checkStats("memwait_stats_hold", 16'd3);

    // Reset pulse while in MEM_WAIT takes effect immediately
    nextCycle(); idle(); exmem_dREN = 1'b1; #1;
    check("rstmw_enter", {9'd0, ctrl}, {9'd0, C_ALL0});
    nextCycle(); idle(); #1;
    check("rstmw_waiting", {9'd0, ctrl}, {9'd0, C_ALL0});
    nRST = 1'b0; #1;
    check("rstmw_ctrl", {9'd0, ctrl}, {9'd0, C_RUN});
    check("rstmw_halt", {15'd0, halt}, 16'd0);
    checkStats("rstmw_stats", 16'd0);
    nRST = 1'b1;
    nextCycle(); idle(); #1;
    check("rstmw_after", {9'd0, ctrl}, {9'd0, C_RUN});

    // Halt: one RUN cycle, three DRAIN cycles, then sticky HALTED
    nextCycle(); idle(); idex_halt = 1'b1; #1;
    check("halt_run", {9'd0, ctrl}, {9'd0, C_HALTR});
    for (int i = 0; i < 3; i++) begin
      nextCycle(); idle(); #1;
      check($sformatf("drain_%0d", i), {9'd0, ctrl}, {9'd0, C_DRAIN});
      check($sformatf("drain_halt_%0d", i), {15'd0, halt}, 16'd0);
    end
    for (int i = 0; i < 3; i++) begin
      nextCycle(); idle(); ex_redirect = 1'b1; #1;
      check($sformatf("halted_%0d", i), {9'd0, ctrl}, {9'd0, C_ALL0});
      check($sformatf("halted_flag_%0d", i), {15'd0, halt}, 16'd1);
    end
    checkStats("halt_stats", 16'd4);

    // Halt with a data miss inside DRAIN: drain stretches to four cycles
    nextCycle(); idle(); doReset(); #1;
    check("rst_clears_halt", {15'd0, halt}, 16'd0);
    nextCycle(); idle(); idex_halt = 1'b1; #1;
    check("halt2_run", {9'd0, ctrl}, {9'd0, C_HALTR});
    nextCycle(); idle(); #1;
    check("drain2_0", {9'd0, ctrl}, {9'd0, C_DRAIN});
    nextCycle(); idle(); exmem_dREN = 1'b1; #1;
    check("drain2_stall", {9'd0, ctrl}, {9'd0, C_ALL0});
    nextCycle(); idle(); #1;
    check("drain2_1", {9'd0, ctrl}, {9'd0, C_DRAIN});
    nextCycle(); idle(); #1;
    check("drain2_2", {9'd0, ctrl}, {9'd0, C_DRAIN});
    check("drain2_halt", {15'd0, halt}, 16'd0);
    nextCycle(); idle(); #1;
    check("halted2", {9'd0, ctrl}, {9'd0, C_ALL0});
    check("halted2_flag", {15'd0, halt}, 16'd1);
    checkStats("halt2_stats", 16'd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports idex_dREN, idex_halt  in  1 each  ID/EX outputs: load in EX, halt in EX.
REQ-004 SHALL have port idex_rt  in  5 (regbits_t)  load destination register.
REQ-005 SHALL have ports ifid_rs, ifid_rt  in  5 each; ifid_usesRt  in  1  decode-stage sources.
REQ-006 SHALL have ports exmem_dREN, exmem_dWEN, dhit, ihit, ex_redirect  in  1 each  memory request, memory hit, fetch hit, branch/jump taken in EX.
REQ-007 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage enables.
REQ-008 SHALL have ports ifid_flush, idex_flush  out  1 each  bubble injection; halt  out  1  sticky halted.
REQ-009 SHALL have port stall_count  out  16 (HAZARD_STATS_EN only)  total stall cycles.

Function
REQ-010 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED (hazard_state_t).
REQ-011 RUN: all enables 1, flushes 0 unless a REQ-012..015 condition holds.
REQ-012 SHALL treat exmem_dREN|exmem_dWEN with dhit=0 as mem stall: all enables 0, flushes 0, same cycle; enter MEM_WAIT next edge.
REQ-013 MEM_WAIT: enables 0 until dhit=1; in the dhit=1 cycle enables 1 (combinational), return to RUN next edge.
REQ-014 SHALL flag load-use when idex_dREN=1, idex_rt!=0, and idex_rt==ifid_rs or (ifid_usesRt and idex_rt==ifid_rt): pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle.
REQ-015 ex_redirect=1: ifid_flush=1, idex_flush=1, pc_en=1; load-use suppressed.
REQ-016 Priority SHALL be mem stall > ex_redirect > load-use > ihit=0.
REQ-017 ihit=0 with no higher condition: pc_en=0, ifid_flush=1, other enables 1.
REQ-018 idex_halt=1 in RUN (no mem stall): pc_en=0, ifid_flush=1; enter DRAIN with 2-bit drain counter=0.
REQ-019 DRAIN: pc_en=0, ifid_flush=1, idex_flush=1; counter increments only when not mem-stalled; at counter==2 enter HALTED.
REQ-020 HALTED: halt=1, all enables 0; leaves only on reset.
REQ-021 Mem stall during DRAIN SHALL freeze the drain counter and apply REQ-012 enables while remaining in DRAIN.
REQ-022 Decode latency: all outputs except halt and stall_count SHALL be combinational from inputs and state.

Reset
REQ-023 nRST=0 SHALL immediately force state RUN, drain counter 0, halt 0, stall_count 0.
REQ-024 Reset mid-MEM_WAIT or mid-DRAIN SHALL abandon the operation; first post-reset cycle behaves as RUN.

Configuration
REQ-025 Macro HAZARD_STATS_EN defined: stall_count increments (saturating at 16'hFFFF) each cycle pc_en=0 and state!=HALTED.
REQ-026 Macro undefined: stall_count port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 hazard_state_t enum and regbits_t SHALL live in cpu_types_pkg; no new package.
REQ-028 SHALL contain one sub-module load_use_detect (pure combinational REQ-014 comparator).

Verification
REQ-029 idex_dREN=1, idex_rt=5, ifid_rs=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle RUN enables.
REQ-030 idex_rt=0, ifid_rs=0, idex_dREN=1 -> no stall.
REQ-031 exmem_dREN=1, dhit=0 for 3 cycles then 1 -> enables 0 for 3 cycles, 1 on 4th; stall_count=3 (HAZARD_STATS_EN).
REQ-032 ex_redirect=1 with simultaneous load-use -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-033 idex_halt=1 -> DRAIN 3 cycles, then halt=1 held; one dhit=0 cycle in DRAIN extends it to 4.
REQ-034 nRST pulse during MEM_WAIT -> halt=0, enables 1, stall_count=0 immediately.
